// File: rtl/brg_xcel_mem_pkg.sv
// Shared payload types and width helpers for the accelerator memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package brg_xcel_mem_pkg;

    localparam int unsigned XCEL_DATA_W = 32;
    localparam int unsigned XCEL_ADDR_W = 32;
    localparam int unsigned XCEL_OPQ_W  = 8;
    localparam int unsigned XCEL_MASK_W = XCEL_DATA_W / 8;
    // Wide enough for the largest supported channel count (16).
    localparam int unsigned XCEL_CHAN_W = 4;

    typedef struct packed {
        logic                   we;
        logic [XCEL_ADDR_W-1:0] addr;
        logic [XCEL_DATA_W-1:0] data;
        logic [XCEL_MASK_W-1:0] mask;
        logic [XCEL_OPQ_W-1:0]  opq;
    } brg_xcel_req_s;

    typedef struct packed {
        logic [XCEL_CHAN_W-1:0] chan;
        logic [XCEL_OPQ_W-1:0]  opq;
    } brg_xcel_tag_entry_s;

    typedef struct packed {
        logic [XCEL_CHAN_W-1:0] chan;
        logic [XCEL_OPQ_W-1:0]  opq;
        logic [XCEL_DATA_W-1:0] data;
    } brg_xcel_ret_s;

    function automatic int unsigned calc_chan_lp(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

    function automatic int unsigned calc_tag_lp(input int unsigned m);
        return int'($clog2(m));
    endfunction

endpackage

// File: rtl/brg_xcel_tag_table.sv
// Outstanding-load tag table: lowest-free allocation, lookup/free on return, popcount.
// Latency: allocation and lookup are combinational; valid bits and count update on the edge.
// Backpressure: avail_o drops when every tag is in flight; a tag freed this cycle is reusable next cycle.
module brg_xcel_tag_table
    import brg_xcel_mem_pkg::*;
#(
    parameter  int unsigned max_out_p       = 8,
    parameter  int unsigned load_id_width_p = 11,
    localparam int unsigned tag_lp          = calc_tag_lp(max_out_p),
    localparam int unsigned tag_idx_lp      = (tag_lp < 1) ? 1 : tag_lp
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       alloc_i,
    input  brg_xcel_tag_entry_s        alloc_entry_i,
    output logic                       avail_o,
    output logic [tag_idx_lp-1:0]      alloc_tag_o,
    input  logic [load_id_width_p-1:0] lookup_id_i,
    output logic                       lookup_hit_o,
    output brg_xcel_tag_entry_s        lookup_entry_o,
    input  logic                       free_i,
    output logic [tag_lp:0]            outstanding_o
);

    logic [max_out_p-1:0]  valid_q, valid_d;
    logic [tag_lp:0]       outstanding_q;
    brg_xcel_tag_entry_s   entry_q [max_out_p];
    logic [tag_idx_lp-1:0] lookup_tag;
    logic                  in_range;
    logic                  alloc_found;

    // Allocation looks only at the registered vector, so a same-cycle free cannot be reused.
    always_comb begin
        alloc_found = 1'b0;
        alloc_tag_o = '0;
        for (int t = 0; t < int'(max_out_p); t++) begin
            if (!alloc_found && !valid_q[t]) begin
                alloc_found = 1'b1;
                alloc_tag_o = tag_idx_lp'(t);
            end
        end
    end

    assign avail_o        = alloc_found;
    assign lookup_tag     = lookup_id_i[tag_idx_lp-1:0];
    assign in_range       = (32'(lookup_id_i) < max_out_p);
    assign lookup_hit_o   = in_range & valid_q[lookup_tag];
    assign lookup_entry_o = entry_q[lookup_tag];
    assign outstanding_o  = outstanding_q;

    always_comb begin
        valid_d = valid_q;
        if (alloc_i) begin
            valid_d[alloc_tag_o] = 1'b1;
        end
        if (free_i && lookup_hit_o) begin
            valid_d[lookup_tag] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_q       <= '0;
            outstanding_q <= '0;
        end else begin
            valid_q       <= valid_d;
            outstanding_q <= (tag_lp + 1)'($countones(valid_d));
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc_i) begin
            entry_q[alloc_tag_o] <= alloc_entry_i;
        end
    end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small generic FIFO, one write port and one read port, register-file storage.
// Latency: 1 cycle from push to v_o; data_o is read combinationally from the head.
// Backpressure: ready_o drops when full; the consumer pops with yumi_i only while v_o is set.
module bsg_fifo_1r1w_small #(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int unsigned PTR_W = (els_p <= 2) ? 1 : $clog2(els_p);
    localparam int unsigned CNT_W = $clog2(els_p + 1);

    logic [width_p-1:0] mem_q [els_p];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push, pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(els_p - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign ready_o = (cnt_q != CNT_W'(els_p));
    assign v_o     = (cnt_q != '0);
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? nxt(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/brg_xcel_mem_arbiter.sv
// Round-robin arbiter of accelerator request channels onto one endpoint port, with load tagging.
// Latency: requests pass through in 0 cycles; responses reach ret_* at least 1 cycle after returned_v_i.
// Backpressure: grants need out_ready_i; returns stall (yumi low) while the response FIFO is full.
module brg_xcel_mem_arbiter
    import brg_xcel_mem_pkg::*;
#(
    parameter  int unsigned num_chan_p      = 4,
    parameter  int unsigned data_width_p    = XCEL_DATA_W,
    parameter  int unsigned addr_width_p    = XCEL_ADDR_W,
    parameter  int unsigned opq_width_p     = XCEL_OPQ_W,
    parameter  int unsigned load_id_width_p = 11,
    parameter  int unsigned max_out_p       = 8,
    parameter  int unsigned ret_fifo_els_p  = 4,
    localparam int unsigned chan_lp         = calc_chan_lp(num_chan_p),
    localparam int unsigned tag_lp          = calc_tag_lp(max_out_p),
    localparam int unsigned mask_width_lp   = data_width_p / 8
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_chan_p-1:0]                 chan_v_i,
    input  logic [num_chan_p-1:0]                 chan_we_i,
    input  logic [num_chan_p*addr_width_p-1:0]    chan_addr_i,
    input  logic [num_chan_p*data_width_p-1:0]    chan_data_i,
    input  logic [num_chan_p*mask_width_lp-1:0]   chan_mask_i,
    input  logic [num_chan_p*opq_width_p-1:0]     chan_opq_i,
    output logic [num_chan_p-1:0]                 chan_rdy_o,
    output logic                                  out_v_o,
    output logic                                  out_we_o,
    output logic [addr_width_p-1:0]               out_addr_o,
    output logic [data_width_p-1:0]               out_data_o,
    output logic [mask_width_lp-1:0]              out_mask_o,
    output logic [load_id_width_p-1:0]            out_load_id_o,
    input  logic                                  out_ready_i,
    input  logic                                  returned_v_i,
    input  logic [load_id_width_p-1:0]            returned_load_id_i,
    input  logic [data_width_p-1:0]               returned_data_i,
    output logic                                  returned_yumi_o,
    output logic                                  ret_v_o,
    output logic [chan_lp-1:0]                    ret_chan_o,
    output logic [opq_width_p-1:0]                ret_opq_o,
    output logic [data_width_p-1:0]               ret_data_o,
    input  logic                                  ret_rdy_i,
    output logic [tag_lp:0]                       outstanding_o,
    output logic                                  err_o
);

    localparam int unsigned tag_idx_lp = (tag_lp < 1) ? 1 : tag_lp;

    logic [chan_lp-1:0]    rr_q, rr_d;
    logic                  err_q, err_d;
    logic [num_chan_p-1:0] elig;
    logic                  gnt_found;
    logic                  gnt_vld;
    logic [chan_lp-1:0]    gnt_idx;
    brg_xcel_req_s         sel_req;
    logic                  load_hs;

    logic                  tag_avail;
    logic [tag_idx_lp-1:0] alloc_tag;
    brg_xcel_tag_entry_s   alloc_entry;
    brg_xcel_tag_entry_s   lookup_entry;
    logic                  lookup_hit;
    logic                  ret_push;

    logic                  fifo_reset;
    logic                  fifo_rdy;
    brg_xcel_ret_s         fifo_in_dat;
    brg_xcel_ret_s         fifo_out_dat;

    // A load is only eligible while a tag is free; stores never need one.
    assign elig = chan_v_i & (chan_we_i | {num_chan_p{tag_avail}});

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < int'(num_chan_p); k++) begin
            if (!gnt_found && elig[(int'(rr_q) + k) % int'(num_chan_p)]) begin
                gnt_found = 1'b1;
                gnt_idx   = chan_lp'((int'(rr_q) + k) % int'(num_chan_p));
            end
        end
    end

    assign gnt_vld    = gnt_found & out_ready_i & reset_i;
    assign chan_rdy_o = gnt_vld ? (num_chan_p'(1) << gnt_idx) : '0;

    always_comb begin
        sel_req.we   = chan_we_i[gnt_idx];
        sel_req.addr = chan_addr_i[int'(gnt_idx)*addr_width_p +: addr_width_p];
        sel_req.data = chan_data_i[int'(gnt_idx)*data_width_p +: data_width_p];
        sel_req.mask = chan_mask_i[int'(gnt_idx)*mask_width_lp +: mask_width_lp];
        sel_req.opq  = chan_opq_i[int'(gnt_idx)*opq_width_p +: opq_width_p];
    end

    assign load_hs       = gnt_vld & ~sel_req.we;
    assign out_v_o       = gnt_vld;
    assign out_we_o      = sel_req.we;
    assign out_addr_o    = sel_req.addr;
    assign out_data_o    = sel_req.data;
    assign out_mask_o    = sel_req.mask;
    assign out_load_id_o = load_hs ? load_id_width_p'(alloc_tag) : '0;

    assign rr_d = gnt_vld ? chan_lp'((int'(gnt_idx) + 1) % int'(num_chan_p)) : rr_q;

    assign alloc_entry.chan = XCEL_CHAN_W'(gnt_idx);
    assign alloc_entry.opq  = sel_req.opq;

    brg_xcel_tag_table #(
        .max_out_p       (max_out_p),
        .load_id_width_p (load_id_width_p)
    ) u_tag_table (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .alloc_i        (load_hs),
        .alloc_entry_i  (alloc_entry),
        .avail_o        (tag_avail),
        .alloc_tag_o    (alloc_tag),
        .lookup_id_i    (returned_load_id_i),
        .lookup_hit_o   (lookup_hit),
        .lookup_entry_o (lookup_entry),
        .free_i         (ret_push),
        .outstanding_o  (outstanding_o)
    );

    // Returns with a stale or out-of-range tag are still consumed, just dropped and flagged.
    assign returned_yumi_o = returned_v_i & fifo_rdy & reset_i;
    assign ret_push        = returned_yumi_o & lookup_hit;
    assign err_d           = err_q | (returned_yumi_o & ~lookup_hit);

    assign fifo_in_dat.chan = lookup_entry.chan;
    assign fifo_in_dat.opq  = lookup_entry.opq;
    assign fifo_in_dat.data = returned_data_i;
    assign fifo_reset       = ~reset_i;

    bsg_fifo_1r1w_small #(
        .width_p ($bits(brg_xcel_ret_s)),
        .els_p   (ret_fifo_els_p)
    ) u_ret_fifo (
        .clk_i   (clk_i),
        .reset_i (fifo_reset),
        .v_i     (ret_push),
        .ready_o (fifo_rdy),
        .data_i  (fifo_in_dat),
        .v_o     (ret_v_o),
        .data_o  (fifo_out_dat),
        .yumi_i  (ret_v_o & ret_rdy_i)
    );

    assign ret_chan_o = chan_lp'(fifo_out_dat.chan);
    assign ret_opq_o  = fifo_out_dat.opq;
    assign ret_data_o = fifo_out_dat.data;
    assign err_o      = err_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_brg_xcel_mem_arbiter.sv
// Directed, table-driven bench for brg_xcel_mem_arbiter (4 channels, 8 tags, 4-entry FIFO).
module tb_brg_xcel_mem_arbiter;

    localparam int NC = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int OW = 8;
    localparam int MW = DW / 8;
    localparam int LW = 11;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [NC-1:0]     chan_v_i, chan_we_i, chan_rdy_o;
    logic [NC*AW-1:0]  chan_addr_i;
    logic [NC*DW-1:0]  chan_data_i;
    logic [NC*MW-1:0]  chan_mask_i;
    logic [NC*OW-1:0]  chan_opq_i;
    logic              out_v_o, out_we_o, out_ready_i;
    logic [AW-1:0]     out_addr_o;
    logic [DW-1:0]     out_data_o;
    logic [MW-1:0]     out_mask_o;
    logic [LW-1:0]     out_load_id_o, returned_load_id_i;
    logic              returned_v_i, returned_yumi_o;
    logic [DW-1:0]     returned_data_i, ret_data_o;
    logic              ret_v_o, ret_rdy_i, err_o;
    logic [1:0]        ret_chan_o;
    logic [OW-1:0]     ret_opq_o;
    logic [3:0]        outstanding_o;

    always #5 clk_i = ~clk_i;

    brg_xcel_mem_arbiter #(
        .num_chan_p(NC), .data_width_p(DW), .addr_width_p(AW), .opq_width_p(OW),
        .load_id_width_p(LW), .max_out_p(8), .ret_fifo_els_p(4)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .chan_v_i(chan_v_i), .chan_we_i(chan_we_i), .chan_addr_i(chan_addr_i),
        .chan_data_i(chan_data_i), .chan_mask_i(chan_mask_i), .chan_opq_i(chan_opq_i),
        .chan_rdy_o(chan_rdy_o),
        .out_v_o(out_v_o), .out_we_o(out_we_o), .out_addr_o(out_addr_o),
        .out_data_o(out_data_o), .out_mask_o(out_mask_o), .out_load_id_o(out_load_id_o),
        .out_ready_i(out_ready_i),
        .returned_v_i(returned_v_i), .returned_load_id_i(returned_load_id_i),
        .returned_data_i(returned_data_i), .returned_yumi_o(returned_yumi_o),
        .ret_v_o(ret_v_o), .ret_chan_o(ret_chan_o), .ret_opq_o(ret_opq_o),
        .ret_data_o(ret_data_o), .ret_rdy_i(ret_rdy_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  we;
        logic        ordy;
        logic [7:0]  opq2;
        logic        rv;
        logic [10:0] rid;
        logic [31:0] rdata;
        logic [3:0]  e_rdy;
        logic [10:0] e_lid;
        logic        e_yumi;
        logic [3:0]  e_out;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_ret(input string n, input logic [1:0] ch, input logic [7:0] opq,
                           input logic [31:0] data);
        check({n, " ret_v"}, 32'(ret_v_o), 32'd1);
        check({n, " ret_chan"}, 32'(ret_chan_o), 32'(ch));
        check({n, " ret_opq"}, 32'(ret_opq_o), 32'(opq));
        check({n, " ret_data"}, ret_data_o, data);
    endtask

    task automatic set_chans(input logic [3:0] v, input logic [3:0] we, input logic [7:0] opq2);
        chan_v_i  = v;
        chan_we_i = we;
        for (int c = 0; c < NC; c++) begin
            chan_addr_i[c*AW +: AW] = 32'h1000 + 32'(c) * 32'h100;
            chan_data_i[c*DW +: DW] = 32'hD000 + 32'(c);
            chan_mask_i[c*MW +: MW] = MW'(c + 1);
            chan_opq_i[c*OW +: OW]  = (c == 2) ? opq2 : OW'(8'h80 + c);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] we, input logic ordy,
                       input logic [7:0] opq2, input logic rv, input logic [10:0] rid,
                       input logic [31:0] rdata, input logic [3:0] e_rdy,
                       input logic [10:0] e_lid, input logic e_yumi, input logic [3:0] e_out);
        vec_t t;
        t.v = v; t.we = we; t.ordy = ordy; t.opq2 = opq2; t.rv = rv; t.rid = rid;
        t.rdata = rdata; t.e_rdy = e_rdy; t.e_lid = e_lid; t.e_yumi = e_yumi; t.e_out = e_out;
        vecs.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Fairness over stores, a stalled cycle, then tag exhaustion and tag-5 reuse.
        add(4'hF, 4'hF, 1, 8'h00, 0, 0, 0, 4'h1, 0, 0, 0);
        add(4'hF, 4'hF, 1, 8'h00, 0, 0, 0, 4'h2, 0, 0, 0);
        add(4'hF, 4'hF, 1, 8'h00, 0, 0, 0, 4'h4, 0, 0, 0);
        add(4'hF, 4'hF, 1, 8'h00, 0, 0, 0, 4'h8, 0, 0, 0);
        add(4'hF, 4'hF, 1, 8'h00, 0, 0, 0, 4'h1, 0, 0, 0);
        add(4'hF, 4'hF, 0, 8'h00, 0, 0, 0, 4'h0, 0, 0, 0);
        add(4'hF, 4'hF, 1, 8'h00, 0, 0, 0, 4'h2, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(4'h4, 4'h0, 1, 8'(8'h10 + k), 0, 0, 0, 4'h4, 11'(k), 0, 4'(k));
        add(4'h6, 4'h2, 1, 8'h18, 0, 0, 0, 4'h2, 0, 0, 4'd8);
        add(4'h4, 4'h0, 1, 8'h18, 1, 11'd5, 32'h55, 4'h0, 0, 1, 4'd8);
        add(4'h4, 4'h0, 1, 8'h18, 0, 0, 0, 4'h4, 11'd5, 0, 4'd7);

        reset_i = 1'b1;
        set_chans(4'hF, 4'hF, 8'h00);
        out_ready_i = 1'b1;
        returned_v_i = 1'b1;
        returned_load_id_i = '0;
        returned_data_i = '0;
        ret_rdy_i = 1'b0;
        #1 reset_i = 1'b0;
        #2;
        check("rst chan_rdy", 32'(chan_rdy_o), 0);
        check("rst out_v", 32'(out_v_o), 0);
        check("rst yumi", 32'(returned_yumi_o), 0);
        check("rst outstanding", 32'(outstanding_o), 0);
        check("rst ret_v", 32'(ret_v_o), 0);
        check("rst err", 32'(err_o), 0);
        tick();
        reset_i = 1'b1;
        returned_v_i = 1'b0;

        foreach (vecs[i]) begin
            int g;
            set_chans(vecs[i].v, vecs[i].we, vecs[i].opq2);
            out_ready_i        = vecs[i].ordy;
            returned_v_i       = vecs[i].rv;
            returned_load_id_i = vecs[i].rid;
            returned_data_i    = vecs[i].rdata;
            ret_rdy_i          = 1'b0;
            #2;
            check($sformatf("vec%0d chan_rdy", i), 32'(chan_rdy_o), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d out_v", i), 32'(out_v_o), 32'(|vecs[i].e_rdy));
            if (vecs[i].e_rdy != 4'h0) begin
                g = 0;
                for (int c = 0; c < NC; c++) if (vecs[i].e_rdy[c]) g = c;
                check($sformatf("vec%0d out_addr", i), out_addr_o, 32'h1000 + 32'(g) * 32'h100);
                check($sformatf("vec%0d out_we", i), 32'(out_we_o), 32'(vecs[i].we[g]));
                check($sformatf("vec%0d load_id", i), 32'(out_load_id_o), 32'(vecs[i].e_lid));
            end
            check($sformatf("vec%0d yumi", i), 32'(returned_yumi_o), 32'(vecs[i].e_yumi));
            check($sformatf("vec%0d outstanding", i), 32'(outstanding_o), 32'(vecs[i].e_out));
            tick();
        end

        // Drain the tag-5 response returned during exhaustion.
        set_chans(4'h0, 4'h0, 8'h00);
        returned_v_i = 1'b0;
        ret_rdy_i = 1'b1;
        #2 chk_ret("tag5", 2'd2, 8'h15, 32'h55);
        tick();
        #2 check("drained ret_v", 32'(ret_v_o), 0);

        // Out-of-order returns: tags 3, 0, 1.
        returned_v_i = 1'b1; returned_load_id_i = 11'd3; returned_data_i = 32'hA;
        #2 check("ooo yumi", 32'(returned_yumi_o), 1);
        tick();
        returned_load_id_i = 11'd0; returned_data_i = 32'hB;
        #2 chk_ret("ooo tag3", 2'd2, 8'h13, 32'hA);
        tick();
        returned_load_id_i = 11'd1; returned_data_i = 32'hC;
        #2 chk_ret("ooo tag0", 2'd2, 8'h10, 32'hB);
        tick();
        returned_v_i = 1'b0;
        #2 chk_ret("ooo tag1", 2'd2, 8'h11, 32'hC);
        tick();
        #2 check("ooo ret_v", 32'(ret_v_o), 0);
        check("ooo outstanding", 32'(outstanding_o), 5);

        // Backpressure: fill the FIFO, fifth return stalls until one pop.
        ret_rdy_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [10:0] ids [4];
            ids = '{11'd2, 11'd4, 11'd5, 11'd6};
            returned_v_i = 1'b1; returned_load_id_i = ids[k]; returned_data_i = 32'hB0 + 32'(k);
            #2 check($sformatf("bp yumi%0d", k), 32'(returned_yumi_o), 1);
            tick();
        end
        returned_load_id_i = 11'd7; returned_data_i = 32'hB4;
        #2 check("bp full yumi", 32'(returned_yumi_o), 0);
        tick();
        #2 check("bp full yumi hold", 32'(returned_yumi_o), 0);
        ret_rdy_i = 1'b1;
        #1 chk_ret("bp pop tag2", 2'd2, 8'h12, 32'hB0);
        check("bp pop-cycle yumi", 32'(returned_yumi_o), 0);
        tick();
        ret_rdy_i = 1'b0;
        #2 check("bp resume yumi", 32'(returned_yumi_o), 1);
        tick();
        returned_v_i = 1'b0;
        ret_rdy_i = 1'b1;
        #2 chk_ret("bp tag4", 2'd2, 8'h14, 32'hB1);
        tick();
        #2 chk_ret("bp tag5", 2'd2, 8'h18, 32'hB2);
        tick();
        #2 chk_ret("bp tag6", 2'd2, 8'h16, 32'hB3);
        tick();
        #2 chk_ret("bp tag7", 2'd2, 8'h17, 32'hB4);
        tick();
        #2 check("bp empty", 32'(ret_v_o), 0);
        check("bp outstanding", 32'(outstanding_o), 0);

        // Return of a free tag is consumed and flagged.
        ret_rdy_i = 1'b0;
        returned_v_i = 1'b1; returned_load_id_i = 11'd6; returned_data_i = 32'hEE;
        #2 check("bad yumi", 32'(returned_yumi_o), 1);
        check("bad err before", 32'(err_o), 0);
        tick();
        returned_v_i = 1'b0;
        #2 check("bad err", 32'(err_o), 1);
        check("bad no push", 32'(ret_v_o), 0);
        tick(); tick();
        #2 check("bad err sticky", 32'(err_o), 1);

        // Reset mid-traffic: five loads from ch0, an out-of-range return, two valid returns.
        out_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_chans(4'h1, 4'h0, 8'h00);
            #2 check($sformatf("ch0 load%0d id", k), 32'(out_load_id_o), 32'(k));
            tick();
        end
        set_chans(4'h0, 4'h0, 8'h00);
        returned_v_i = 1'b1; returned_load_id_i = 11'd8; returned_data_i = 32'h99;
        #2 check("oor yumi", 32'(returned_yumi_o), 1);
        tick();
        returned_load_id_i = 11'd0; returned_data_i = 32'h90;
        #2 check("oor no free", 32'(outstanding_o), 5);
        check("oor no push", 32'(ret_v_o), 0);
        tick();
        returned_load_id_i = 11'd1; returned_data_i = 32'h91;
        tick();
        returned_v_i = 1'b0;
        #2 check("mid outstanding", 32'(outstanding_o), 3);
        check("mid ret_v", 32'(ret_v_o), 1);
        reset_i = 1'b0;
        returned_v_i = 1'b1;
        #1 check("async rst outstanding", 32'(outstanding_o), 0);
        check("async rst ret_v", 32'(ret_v_o), 0);
        check("async rst err", 32'(err_o), 0);
        check("async rst yumi", 32'(returned_yumi_o), 0);
        tick();
        reset_i = 1'b1;
        returned_v_i = 1'b0;
        set_chans(4'hF, 4'hF, 8'h00);
        #2 check("post rst grant", 32'(chan_rdy_o), 32'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
